// File: rtl/pulse_timer_pkg.sv
// pulse_timer_pkg: shared types and defaults for the programmable pulse timer
//   timer_state_t : IDLE / RUN / DONE control states
//   DEF_N         : default datapath width
package pulse_timer_pkg;

    localparam int DEF_N = 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} timer_state_t;

endpackage

// File: rtl/comparator_eq.sv
// comparator_eq: combinational N-bit equality comparator
//   a, b : operands
//   out  : high when a equals b
module comparator_eq #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out
);

    assign out = (a == b);

endmodule

// File: rtl/pulse_timer.sv
// pulse_timer: programmable period counter emitting a one-cycle tick every period enabled cycles
//   clk, rst  : clock, synchronous active-high reset
//   ena       : count enable
//   start     : latch period/one_shot and (re)start counting
//   stop      : abort counting, return to idle
//   one_shot  : 1 = stop after first tick, 0 = auto-reload
//   period    : tick interval in enabled cycles (0 treated as 1)
//   count     : current counter value
//   tick      : registered one-cycle pulse at terminal count
//   busy      : high while running
module pulse_timer
    import pulse_timer_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic         one_shot,
    input  logic [N-1:0] period,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         busy
);

    timer_state_t state;
    logic [N-1:0] period_q;
    logic         mode_q;
    logic [N-1:0] term;
    logic         hit;

    // Only the terminal value is derived by subtraction; count stops at term,
    // so a full-scale period never needs an extra counter bit.
    assign term = period_q - N'(1);
    assign busy = (state == S_RUN);

    comparator_eq #(.N(N)) u_cmp (
        .a   (count),
        .b   (term),
        .out (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            tick     <= 1'b0;
            period_q <= N'(1);
            mode_q   <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else if (start) begin
                        count    <= '0;
                        period_q <= (period == '0) ? N'(1) : period;
                        mode_q   <= one_shot;
                    end else if (ena) begin
                        if (hit) begin
                            tick  <= 1'b1;
                            count <= '0;
                            state <= mode_q ? S_DONE : S_RUN;
                        end else begin
                            count <= count + N'(1);
                        end
                    end
                end
                // IDLE and the single DONE cycle both accept a new start.
                default: begin
                    count <= '0;
                    state <= start ? S_RUN : S_IDLE;
                    if (start) begin
                        period_q <= (period == '0) ? N'(1) : period;
                        mode_q   <= one_shot;
                    end
                end
            endcase
        end
    end

endmodule
